ram_arbiter: RTL and testbench



---
 rtl/ram_pkg.sv | 26 ++
 rtl/ram_arbiter_rr_arb2.sv | 32 +++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAMHelper arbiter slice.
package ram_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned STRB_W    = 8;
  localparam int unsigned OFF_SHIFT = 3;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              err;
  } resp_t;

  // Expand one strobe bit per byte into a full byte-lane bit mask.
  function automatic logic [WORD_W-1:0] strb2mask(input logic [STRB_W-1:0] strb);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(STRB_W); i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_D;
    end else if (advance && (|gnt)) begin
      r_last <= gnt[1] ? OWN_D : OWN_IF;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAMHelper port between instruction fetch and load/store,
// holding a single response until its owner accepts it.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter logic [63:0] RAM_BASE  = 64'h8000_0000,
  parameter logic [63:0] RAM_WORDS = 64'h0800_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [WORD_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [WORD_W-1:0] if_resp_data,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [WORD_W-1:0] d_req_addr,
  input  logic              d_req_wen,
  input  logic [WORD_W-1:0] d_req_wdata,
  input  logic [STRB_W-1:0] d_req_wstrb,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [WORD_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic              ram_en,
  output logic [WORD_W-1:0] ram_rIdx,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [WORD_W-1:0] ram_wIdx,
  output logic [WORD_W-1:0] ram_wdata,
  output logic [WORD_W-1:0] ram_wmask,
  output logic              ram_wen
);

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_own;
  owner_e            w_win;
  resp_t             r_resp;
  logic              w_owner_ready;
  logic              w_acc;
  logic              w_fire;
  logic              w_inrange;
  logic              w_wen;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_off;

  assign w_owner_ready = (r_own == OWN_IF) ? if_resp_ready : d_resp_ready;
  assign w_acc         = rst_n && ((r_state == IDLE) || w_owner_ready);
  assign w_req         = {d_req_valid, if_req_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_fire),
    .gnt     (w_gnt)
  );

  assign w_fire       = w_acc && (|w_gnt);
  assign if_req_ready = w_acc && w_gnt[0];
  assign d_req_ready  = w_acc && w_gnt[1];
  assign w_win        = w_gnt[1] ? OWN_D : OWN_IF;
  assign w_addr       = w_gnt[1] ? d_req_addr : if_req_addr;
  assign w_off        = WORD_W'((w_addr - RAM_BASE) >> OFF_SHIFT);
  assign w_inrange    = (w_addr >= RAM_BASE) && (w_off < RAM_WORDS);
  assign w_wen        = w_gnt[1] && d_req_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new grant always (re)loads the holding register; otherwise a taken response frees it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) begin
      w_state_nxt = RESP;
    end else if ((r_state == RESP) && w_owner_ready) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    if_resp_valid = 1'b0;
    d_resp_valid  = 1'b0;
    ram_en        = 1'b0;
    ram_wen       = 1'b0;
    ram_rIdx      = '0;
    ram_wIdx      = '0;
    ram_wdata     = '0;
    ram_wmask     = '0;
    if (r_state == RESP) begin
      if_resp_valid = (r_own == OWN_IF);
      d_resp_valid  = (r_own == OWN_D);
    end
    if (w_fire && w_inrange) begin
      ram_en   = 1'b1;
      ram_rIdx = w_off;
      ram_wIdx = w_off;
      if (w_gnt[1]) begin
        ram_wen   = d_req_wen;
        ram_wdata = d_req_wdata;
        ram_wmask = strb2mask(d_req_wstrb);
      end
    end
  end

  // Writes acknowledge with zero data; out-of-range accesses return zero with err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp <= '0;
      r_own  <= OWN_IF;
    end else if (w_fire) begin
      r_own       <= w_win;
      r_resp.data <= (w_inrange && !w_wen) ? ram_rdata : '0;
      r_resp.err  <= !w_inrange;
    end
  end

  assign if_resp_data = r_resp.data;
  assign if_resp_err  = r_resp.err;
  assign d_resp_data  = r_resp.data;
  assign d_resp_err   = r_resp.err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model and a sparse RAMHelper stand-in.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] WORDS = 64'h0800_0000;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
  logic [63:0] if_req_addr, if_resp_data;
  logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_ready, d_resp_err;
  logic [63:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [7:0]  d_req_wstrb;
  logic        ram_en, ram_wen;
  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.RAM_BASE(BASE), .RAM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .ram_en(ram_en), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [63:0] env_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  function automatic logic [63:0] init_word(input logic [63:0] idx);
    return {32'hDEAD_BEEF, idx[31:0]};
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // RAMHelper stand-in: read then write on the negedge of an enabled cycle.
  initial ram_rdata = '0;
  always @(negedge clk) begin
    logic [63:0] old;
    if (ram_en) begin
      old = env_mem.exists(ram_rIdx) ? env_mem[ram_rIdx] : init_word(ram_rIdx);
      ram_rdata = old;
      if (ram_wen) begin
        old = env_mem.exists(ram_wIdx) ? env_mem[ram_wIdx] : init_word(ram_wIdx);
        env_mem[ram_wIdx] = (old & ~ram_wmask) | (ram_wdata & ram_wmask);
      end
    end
  end

  // Reference model state: one optional held response plus who was served last.
  bit          m_pend, m_own, m_err, m_last;
  logic [63:0] m_data, m_off;
  int          m_win;
  bit          m_fire, m_inr, m_wr, m_if_acc, m_d_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_own = 0; m_err = 0; m_last = 1; m_data = '0;
    m_if_acc = 0; m_d_acc = 0;
  endtask

  task automatic model_eval();
    bit can;
    logic [63:0] a;
    can = rst_n && (!m_pend || (m_own ? d_resp_ready : if_resp_ready));
    if (if_req_valid && d_req_valid) m_win = m_last ? 0 : 1;
    else if (if_req_valid)           m_win = 0;
    else if (d_req_valid)            m_win = 1;
    else                             m_win = -1;
    m_fire = can && (m_win >= 0);
    a      = (m_win == 1) ? d_req_addr : if_req_addr;
    m_off  = (a - BASE) / 64'd8;
    m_inr  = (a >= BASE) && (m_off < WORDS);
    m_wr   = m_fire && m_inr && (m_win == 1) && d_req_wen;
  endtask

  task automatic model_update();
    logic [63:0] old;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_eval();
      m_if_acc = m_fire && (m_win == 0);
      m_d_acc  = m_fire && (m_win == 1);
      if (m_fire) begin
        m_pend = 1; m_own = (m_win == 1); m_last = m_own;
        m_err  = !m_inr; m_data = '0;
        if (m_inr) begin
          old = ref_mem.exists(m_off) ? ref_mem[m_off] : init_word(m_off);
          if (m_wr) ref_mem[m_off] = (old & ~byte_mask(d_req_wstrb)) | (d_req_wdata & byte_mask(d_req_wstrb));
          else      m_data = old;
        end
      end else if (m_pend && (m_own ? d_resp_ready : if_resp_ready)) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_all();
    bit en, dw;
    #2;
    model_eval();
    en = m_fire && m_inr;
    dw = en && (m_win == 1);
    chk("if_req_ready", if_req_ready, m_fire && (m_win == 0));
    chk("d_req_ready", d_req_ready, m_fire && (m_win == 1));
    chk("ram_en", ram_en, en);
    chk("ram_rIdx", ram_rIdx, en ? m_off : 64'd0);
    chk("ram_wIdx", ram_wIdx, en ? m_off : 64'd0);
    chk("ram_wen", ram_wen, m_wr);
    chk("ram_wdata", ram_wdata, dw ? d_req_wdata : 64'd0);
    chk("ram_wmask", ram_wmask, dw ? byte_mask(d_req_wstrb) : 64'd0);
    chk("if_resp_valid", if_resp_valid, m_pend && !m_own);
    chk("d_resp_valid", d_resp_valid, m_pend && m_own);
    if (m_pend && !m_own) begin
      chk("if_resp_data", if_resp_data, m_data);
      chk("if_resp_err", if_resp_err, m_err);
    end
    if (m_pend && m_own) begin
      chk("d_resp_data", d_resp_data, m_data);
      chk("d_resp_err", d_resp_err, m_err);
    end
  endtask

  task automatic set_if(input bit v, input logic [63:0] a);
    if_req_valid = v; if_req_addr = a;
  endtask

  task automatic set_d(input bit v, input logic [63:0] a, input bit w,
                       input logic [63:0] wd, input logic [7:0] st);
    d_req_valid = v; d_req_addr = a; d_req_wen = w; d_req_wdata = wd; d_req_wstrb = st;
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return BASE - 64'd8 + 64'($urandom_range(0, 7));
    if (r == 1) return BASE + (WORDS * 64'd8) + 64'($urandom_range(0, 7));
    if (r == 2) return BASE + ((WORDS - 64'd1) * 64'd8) + 64'($urandom_range(0, 7));
    return BASE + 64'($urandom_range(0, 255));
  endfunction

  task automatic drive_random();
    if (!(if_req_valid && !m_if_acc)) begin
      if_req_valid = ($urandom_range(0, 99) < 60);
      if_req_addr  = rand_addr();
    end
    if (!(d_req_valid && !m_d_acc)) begin
      d_req_valid = ($urandom_range(0, 99) < 60);
      d_req_addr  = rand_addr();
      d_req_wen   = $urandom_range(0, 1);
      d_req_wdata = {$urandom, $urandom};
      d_req_wstrb = 8'($urandom);
    end
    if_resp_ready = ($urandom_range(0, 99) < 70);
    d_resp_ready  = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    logic [63:0] held;
    rst_n = 1'b0;
    set_if(0, '0); set_d(0, '0, 0, '0, '0);
    if_resp_ready = 1'b0; d_resp_ready = 1'b0;
    model_reset();

    // Reset state
    #13;
    chk("rst_if_req_ready", if_req_ready, 0);
    chk("rst_d_req_ready", d_req_ready, 0);
    chk("rst_if_resp_valid", if_resp_valid, 0);
    chk("rst_d_resp_valid", d_resp_valid, 0);
    chk("rst_resp_data", if_resp_data, 0);
    chk("rst_resp_err", d_resp_err, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_wmask", ram_wmask, 0);
    rst_n = 1'b1;

    // Single read
    tick(); set_if(1, 64'h8000_0010); if_resp_ready = 1'b1; check_all();
    chk("sr_ridx", ram_rIdx, 64'd2);
    tick(); set_if(0, '0); check_all();
    chk("sr_data", if_resp_data, 64'hDEAD_BEEF_0000_0002);
    chk("sr_err", if_resp_err, 0);

    // Strobed write then read back
    tick(); set_d(1, 64'h8000_0008, 1, 64'h1122_3344_5566_7788, 8'h0F); d_resp_ready = 1'b1;
    check_all();
    chk("wr_mask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
    chk("wr_wen", ram_wen, 1);
    chk("wr_widx", ram_wIdx, 64'd1);
    tick(); set_d(1, 64'h8000_0008, 0, '0, '0); check_all();
    tick(); set_d(0, '0, 0, '0, '0); check_all();
    chk("wr_merge", d_resp_data, 64'hDEAD_BEEF_5566_7788);

    // Tie: alternating grants starting with IF (D was served last)
    for (int k = 0; k < 4; k++) begin
      tick(); set_if(1, 64'h8000_0020); set_d(1, 64'h8000_0100, 0, '0, '0);
      if_resp_ready = 1'b1; d_resp_ready = 1'b1; check_all();
      chk("tie_if_gnt", if_req_ready, (k % 2) == 0);
      chk("tie_d_gnt", d_req_ready, (k % 2) == 1);
    end

    // Backpressure on D response while IF waits
    tick(); set_if(0, '0); set_d(1, 64'h8000_0040, 0, '0, '0); check_all();
    for (int k = 0; k < 3; k++) begin
      tick(); set_d(0, '0, 0, '0, '0); set_if(1, 64'h8000_0048); d_resp_ready = 1'b0;
      check_all();
      if (k == 0) held = d_resp_data;
      chk("bp_if_ready", if_req_ready, 0);
      chk("bp_ram_en", ram_en, 0);
      chk("bp_d_data", d_resp_data, held);
    end
    tick(); d_resp_ready = 1'b1; check_all();
    chk("bp_if_grant", if_req_ready, 1);
    tick(); set_if(0, '0); check_all();

    // Out of range
    tick(); set_d(1, 64'h7FFF_FFF8, 0, '0, '0); check_all();
    chk("oor_en", ram_en, 0);
    tick(); set_d(0, '0, 0, '0, '0); check_all();
    chk("oor_valid", d_resp_valid, 1);
    chk("oor_data", d_resp_data, 0);
    chk("oor_err", d_resp_err, 1);

    // Reset while a response is held
    tick(); set_if(1, 64'h8000_0020); if_resp_ready = 1'b0; check_all();
    tick(); set_if(0, '0); check_all();
    #1 rst_n = 1'b0;
    #1 chk("rr_if_valid", if_resp_valid, 0);
    model_reset();
    tick(); rst_n = 1'b1;
    set_if(1, 64'h8000_0030); set_d(1, 64'h8000_0038, 0, '0, '0);
    if_resp_ready = 1'b1; d_resp_ready = 1'b1;
    check_all();
    chk("rr_tie_if", if_req_ready, 1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      tick(); drive_random(); check_all();
    end
    tick(); set_if(0, '0); set_d(0, '0, 0, '0, '0);
    if_resp_ready = 1'b1; d_resp_ready = 1'b1; check_all();
    tick(); check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
